// File: rtl/gf_poly_eval.sv
// Streaming GF(2^8) Horner evaluator: folds a frame of coefficient bytes (highest
// order first) into r = sum c_i * p^(n-1-i), then holds the result until taken.
module gf_poly_eval #(
    parameter logic [7:0] POLY  = 8'h1B,
    parameter int         LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    input  logic [7:0]       point,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic [LEN_W-1:0] out_len
);

    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    state_t             state, state_d;
    logic [7:0]         acc, acc_d;
    logic [7:0]         p_reg, p_d;
    logic [LEN_W-1:0]   len, len_d;
    logic               accept;

    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? POLY : 8'h00);
    endfunction

    // Shift-and-add multiply: LSB of b first, a doubled each step.
    function automatic logic [7:0] gfmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r, v;
        r = 8'h00;
        v = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ v;
            v = xtime(v);
        end
        return r;
    endfunction

    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);
    assign out_data  = out_valid ? acc : 8'h00;
    assign out_len   = out_valid ? len : '0;
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d = state;
        acc_d   = acc;
        p_d     = p_reg;
        len_d   = len;
        case (state)
            IDLE: if (accept) begin
                p_d     = point;
                acc_d   = in_data;
                len_d   = LEN_W'(1);
                state_d = in_last ? HOLD : ACC;
            end
            ACC: if (accept) begin
                // Length saturates; the accumulator keeps folding regardless.
                acc_d   = gfmul(acc, p_reg) ^ in_data;
                len_d   = (len == {LEN_W{1'b1}}) ? len : len + LEN_W'(1);
                state_d = in_last ? HOLD : ACC;
            end
            HOLD: if (out_ready) begin
                acc_d   = 8'h00;
                len_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= 8'h00;
            p_reg <= 8'h00;
            len   <= '0;
        end else begin
            state <= state_d;
            acc   <= acc_d;
            p_reg <= p_d;
            len   <= len_d;
        end
    end

endmodule

// File: doc/gf_poly_eval.md
Name: gf_poly_eval

Overview:
- Streaming GF(2^8) polynomial evaluator. Consumes a frame of coefficient bytes, highest order first, over a valid/ready handshake.
- Computes r = c0*p^(n-1) ^ c1*p^(n-2) ^ ... ^ c(n-1) by Horner's rule, using the same field arithmetic as the team's combinational garoaCal multiplier.
- Sits downstream of the byte source and feeds syndrome/check logic. Typical use is Reed-Solomon syndrome evaluation at p = alpha^j.

Parameters:
- POLY, 8'h1B, low 8 bits of the field reduction polynomial (x^8 implied; default x^8+x^4+x^3+x+1).
- LEN_W, 8, width of the frame length counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  coefficient byte valid
- in_ready  output  1  block can accept a byte
- in_data  input  8  coefficient byte
- in_last  input  1  marks the final byte of the frame; qualified by in_valid
- point  input  8  evaluation point p; sampled on the first accepted byte of a frame
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts the result
- out_data  output  8  evaluated value r
- out_len  output  LEN_W  number of bytes in the frame, saturating

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=IDLE, acc=0, p_reg=0, len=0, in_ready=1, out_valid=0, out_data=0, out_len=0.
- Beat acceptance: a byte is accepted when in_valid && in_ready at the rising edge.
- gfmul(a,b): combinational shift-and-add over 8 bits. Each step is xtime(v) = {v[6:0],1'b0} ^ (v[7] ? POLY : 0). Results are always 8 bits; no carries.
- FSM:
  - IDLE: in_ready=1. On accept: p_reg<=point, acc<=in_data, len<=1. Next state is HOLD if in_last, else ACC.
  - ACC: in_ready=1. On accept: acc<=gfmul(acc,p_reg)^in_data, len<=sat(len+1). Next state is HOLD if in_last, else stay in ACC. With no accept, all state holds.
  - HOLD: in_ready=0, out_valid=1, out_data=acc, out_len=len. When out_ready=1: out_valid drops next cycle, acc/len clear, next state IDLE.
- Latency: out_valid rises the cycle after the last byte is accepted. Throughput is one byte per cycle within a frame.
- Frame gap: minimum gap between frames is 2 cycles (HOLD plus handshake). The next frame's first byte is accepted no earlier than the cycle after the output handshake.
- Output stability: out_data and out_len stay stable while out_valid=1 && out_ready=0.
- point: changes to point mid-frame are ignored; only the first-beat sample is used.
- Single-byte frame (in_last on the first beat): r = that byte; p is unused.
- out_len saturates at 2^LEN_W-1 and never wraps. acc continues updating past saturation.
- out_ready asserted while out_valid=0 has no effect.
- in_data/in_last while in_ready=0 are ignored.
- Reset mid-frame or in HOLD returns all state to reset values next cycle. The partial frame is discarded, no output is produced, and the next accepted byte starts a new frame.

Test Plan:
- Reset, then frame [0x56] with last, point=0x12 -> next cycle out_valid=1, out_data=0x56, out_len=1; out_ready=1 -> IDLE.
- point=0x02, frame [0x80,0x00] -> out_data=0x1B (reduction path), out_len=2.
- point=0x57, frame [0x83,0x00] -> 0xC1. Then point=0x53, frame [0xCA,0x01] -> 0x00 (0x53*0xCA=0x01).
- point=0x00, frame [0x12,0x34,0x56] with in_valid gaps and point toggled to 0xFF mid-frame -> out_data=0x56, out_len=3.
- Back-pressure: hold out_ready=0 for 5 cycles after a result -> out_valid, out_data, out_len constant; in_ready=0; bytes offered are not consumed.
- Reset on the 2nd byte of a 3-byte frame, then frame [0x4C] -> out_data=0x4C, out_len=1, no stale result emitted. Also run a 300-byte frame -> out_len=0xFF.
